// File: rtl/dmem_access_ctrl_pkg.sv
// Shared types for the memory-stage access controller: bus structs, access size
// encoding and the controller state enum.
package dmem_access_ctrl_pkg;

  localparam int DATA_W = 64;

  typedef enum logic [1:0] {
    MSIZE1 = 2'd0,
    MSIZE2 = 2'd1,
    MSIZE4 = 2'd2,
    MSIZE8 = 2'd3
  } msize_t;

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] addr;
    msize_t            size;
    logic [7:0]        strobe;
    logic [DATA_W-1:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic              data_ok;
    logic [DATA_W-1:0] data;
  } dbus_resp_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } mem_ctl_state_t;

  // Byte-enable pattern of an access at lane 0.
  function automatic logic [7:0] size_strobe(input msize_t s);
    logic [7:0] b;
    case (s)
      MSIZE1:  b = 8'h01;
      MSIZE2:  b = 8'h03;
      MSIZE4:  b = 8'h0f;
      default: b = 8'hff;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/dmem_access_ctrl_lane_fmt.sv
// Byte-lane formatting for data memory: store shift/strobe and load
// extract/extend. Pure combinational so it can be shared with other paths.
module mem_lane_fmt
  import dmem_access_ctrl_pkg::*;
(
  input  msize_t            size_i,
  input  logic              unsigned_i,
  input  logic [2:0]        addr_lo_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [DATA_W-1:0] rdata_i,
  output logic [DATA_W-1:0] st_data_o,
  output logic [7:0]        st_strobe_o,
  output logic [DATA_W-1:0] ld_data_o
);

  logic [5:0]        bit_sh;
  logic [DATA_W-1:0] rd_sh;

  assign bit_sh      = {addr_lo_i, 3'b000};
  assign st_data_o   = wdata_i << bit_sh;
  assign st_strobe_o = size_strobe(size_i) << addr_lo_i;
  assign rd_sh       = rdata_i >> bit_sh;

  always_comb begin
    ld_data_o = rd_sh;
    case (size_i)
      MSIZE1:  ld_data_o = unsigned_i ? {56'd0, rd_sh[7:0]}
                                      : {{56{rd_sh[7]}}, rd_sh[7:0]};
      MSIZE2:  ld_data_o = unsigned_i ? {48'd0, rd_sh[15:0]}
                                      : {{48{rd_sh[15]}}, rd_sh[15:0]};
      MSIZE4:  ld_data_o = unsigned_i ? {32'd0, rd_sh[31:0]}
                                      : {{32{rd_sh[31]}}, rd_sh[31:0]};
      default: ld_data_o = rd_sh;
    endcase
  end

endmodule

// File: rtl/dmem_access_ctrl.sv
// Memory-stage data access sequencer: issues one dbus request per load/store,
// stalls until data_ok, then holds the result until the pipeline advances.
module dmem_access_ctrl
  import dmem_access_ctrl_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            mem_valid,
  input  logic            mem_write,
  input  msize_t          mem_size,
  input  logic            mem_unsigned,
  input  logic [XLEN-1:0] mem_addr,
  input  logic [XLEN-1:0] mem_wdata,
  input  logic            advance,
  output dbus_req_t       dreq,
  input  dbus_resp_t      dresp,
  output logic            stall,
  output logic [XLEN-1:0] load_data,
  output logic            done,
  output logic            misalign,
  output mem_ctl_state_t  state_dbg
);

  // Handshake: dreq.valid stays high from the first WAIT cycle until the
  // cycle dresp.data_ok is seen; the request fields are held stable by the
  // stall. data_ok outside WAIT (e.g. after a reset) is ignored.

  mem_ctl_state_t  state_q;
  logic            valid_q;
  logic            done_q;
  logic [XLEN-1:0] data_q;
  logic [XLEN-1:0] st_data;
  logic [7:0]      st_strobe;
  logic [XLEN-1:0] ld_data;
  logic            start;

  always_comb begin
    misalign = 1'b0;
    case (mem_size)
      MSIZE2:  misalign = mem_addr[0];
      MSIZE4:  misalign = |mem_addr[1:0];
      MSIZE8:  misalign = |mem_addr[2:0];
      default: misalign = 1'b0;
    endcase
    misalign = misalign & mem_valid;
  end

  assign start = mem_valid && !misalign;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      data_q  <= '0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          state_q <= WAIT;
          valid_q <= 1'b1;
        end
        WAIT: if (dresp.data_ok) begin
          state_q <= DONE;
          valid_q <= 1'b0;
          done_q  <= 1'b1;
          data_q  <= dresp.data;
        end
        DONE: if (advance) begin
          state_q <= IDLE;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          valid_q <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  mem_lane_fmt u_fmt (
    .size_i      (mem_size),
    .unsigned_i  (mem_unsigned),
    .addr_lo_i   (mem_addr[2:0]),
    .wdata_i     (mem_wdata),
    .rdata_i     (data_q),
    .st_data_o   (st_data),
    .st_strobe_o (st_strobe),
    .ld_data_o   (ld_data)
  );

  always_comb begin
    dreq        = '0;
    dreq.valid  = valid_q;
    dreq.addr   = mem_addr;
    dreq.size   = mem_size;
    dreq.strobe = mem_write ? st_strobe : 8'h00;
    dreq.data   = st_data;
  end

  // IDLE stalls combinationally on detect so the EX/MEM register never
  // moves past an access that has not been issued yet.
  assign stall     = (state_q == WAIT) || ((state_q == IDLE) && start);
  assign done      = done_q;
  assign load_data = ld_data;
  assign state_dbg = state_q;

  a_valid_held_in_wait: assert property (
    @(posedge clk) disable iff (reset) (state_q == WAIT) |-> mem_valid
  );

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench for dmem_access_ctrl: driver tasks push expected bus requests
// and load results; a negedge monitor pops and compares them.
module tb_dmem_access_ctrl;
  import dmem_access_ctrl_pkg::*;

  logic           clk = 1'b0;
  logic           reset;
  logic           mem_valid, mem_write, mem_unsigned, advance;
  msize_t         mem_size;
  logic [63:0]    mem_addr, mem_wdata;
  dbus_req_t      dreq;
  dbus_resp_t     dresp;
  logic           stall, done, misalign;
  logic [63:0]    load_data;
  mem_ctl_state_t state_dbg;

  int checks = 0;
  int errors = 0;

  dbus_req_t   exp_req_q[$];
  logic [63:0] exp_q[$];
  logic        valid_prev = 1'b0;
  logic        done_prev  = 1'b0;

  dmem_access_ctrl #(.XLEN(64)) dut (
    .clk          (clk),
    .reset        (reset),
    .mem_valid    (mem_valid),
    .mem_write    (mem_write),
    .mem_size     (mem_size),
    .mem_unsigned (mem_unsigned),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .advance      (advance),
    .dreq         (dreq),
    .dresp        (dresp),
    .stall        (stall),
    .load_data    (load_data),
    .done         (done),
    .misalign     (misalign),
    .state_dbg    (state_dbg)
  );

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (!reset) begin
      if (dreq.valid && !valid_prev) begin
        if (exp_req_q.size() == 0) check("unexpected_req", 64'd1, 64'd0);
        else begin
          dbus_req_t e;
          e = exp_req_q.pop_front();
          check("req_addr",   dreq.addr,   e.addr);
          check("req_size",   {62'd0, dreq.size}, {62'd0, e.size});
          check("req_strobe", {56'd0, dreq.strobe}, {56'd0, e.strobe});
          check("req_data",   dreq.data,   e.data);
        end
      end
      if (done && !done_prev && !mem_write) begin
        if (exp_q.size() == 0) check("unexpected_load", 64'd1, 64'd0);
        else check("load_data", load_data, exp_q.pop_front());
      end
    end
    valid_prev = dreq.valid;
    done_prev  = done;
  end

  // Driver: one complete access; data_ok arrives in WAIT cycle number lat.
  task automatic do_access(input logic wr, input msize_t sz, input logic uns,
                           input logic [63:0] addr, input logic [63:0] wdata,
                           input logic [63:0] rdata, input int lat, input int hold,
                           input logic [7:0] exp_strobe, input logic [63:0] exp_data,
                           input logic [63:0] exp_load);
    int k, n;
    dbus_req_t r;
    r = '0;
    r.valid = 1'b1; r.addr = addr; r.size = sz; r.strobe = exp_strobe; r.data = exp_data;
    exp_req_q.push_back(r);
    if (!wr) exp_q.push_back(exp_load);
    @(posedge clk); #1;
    mem_valid = 1'b1; mem_write = wr; mem_size = sz; mem_unsigned = uns;
    mem_addr = addr; mem_wdata = wdata; advance = 1'b0;
    k = 0; n = 0;
    while (k < 40) begin
      dresp.data_ok = (k == lat);
      dresp.data    = rdata;
      @(negedge clk);
      if (done) break;
      if (stall) n++;
      @(posedge clk); #1;
      k++;
    end
    dresp.data_ok = 1'b0;
    check("done_timeout", {63'd0, k >= 40}, 64'd0);
    check("stall_cycles", n, lat + 1);
    check("done_valid_low", {63'd0, dreq.valid}, 64'd0);
    check("done_stall_low", {63'd0, stall}, 64'd0);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      @(negedge clk);
      check("hold_done", {63'd0, done}, 64'd1);
      check("hold_valid", {63'd0, dreq.valid}, 64'd0);
      if (!wr) check("hold_load_data", load_data, exp_load);
    end
    @(posedge clk); #1;
    advance = 1'b1;
    @(posedge clk); #1;
    advance = 1'b0; mem_valid = 1'b0;
    @(negedge clk);
    check("after_adv_state", {62'd0, state_dbg}, {62'd0, IDLE});
    check("after_adv_done", {63'd0, done}, 64'd0);
  endtask

  task automatic misalign_case(input msize_t sz, input logic [63:0] addr);
    @(posedge clk); #1;
    mem_valid = 1'b1; mem_write = 1'b0; mem_size = sz; mem_unsigned = 1'b0;
    mem_addr = addr; mem_wdata = 64'd0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("misalign_flag", {63'd0, misalign}, 64'd1);
      check("misalign_stall", {63'd0, stall}, 64'd0);
      check("misalign_valid", {63'd0, dreq.valid}, 64'd0);
    end
    @(posedge clk); #1;
    mem_valid = 1'b0;
    @(negedge clk);
    check("misalign_clear", {63'd0, misalign}, 64'd0);
  endtask

  initial begin
    reset = 1'b1; mem_valid = 1'b0; mem_write = 1'b0; mem_size = MSIZE1;
    mem_unsigned = 1'b0; mem_addr = 64'd0; mem_wdata = 64'd0; advance = 1'b0;
    dresp = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_state", {62'd0, state_dbg}, {62'd0, IDLE});
    check("rst_valid", {63'd0, dreq.valid}, 64'd0);
    check("rst_stall", {63'd0, stall}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_load_data", load_data, 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // LD, 4 stall cycles
    do_access(1'b0, MSIZE8, 1'b0, 64'h8000_1000, 64'd0, 64'h1122334455667788, 3, 0,
              8'h00, 64'd0, 64'h1122334455667788);
    // LB / LBU of byte 3
    do_access(1'b0, MSIZE1, 1'b0, 64'h8000_1003, 64'd0, 64'h0000000080000000, 1, 0,
              8'h00, 64'd0, 64'hFFFFFFFFFFFFFF80);
    do_access(1'b0, MSIZE1, 1'b1, 64'h8000_1003, 64'd0, 64'h0000000080000000, 1, 0,
              8'h00, 64'd0, 64'h0000000000000080);
    // SH at lane 6
    do_access(1'b1, MSIZE2, 1'b0, 64'h8000_1006, 64'h000000000000ABCD, 64'd0, 2, 0,
              8'hC0, 64'hABCD000000000000, 64'd0);
    // LW upper word, held 5 cycles without advance
    do_access(1'b0, MSIZE4, 1'b0, 64'h8000_2004, 64'd0, 64'h8765432100000000, 1, 5,
              8'h00, 64'd0, 64'hFFFFFFFF87654321);
    // SW upper word
    do_access(1'b1, MSIZE4, 1'b0, 64'h8000_0004, 64'h00000000DEADBEEF, 64'd0, 1, 0,
              8'hF0, 64'hDEADBEEF00000000, 64'd0);
    // LHU / LH of halfword 1
    do_access(1'b0, MSIZE2, 1'b1, 64'h8000_0002, 64'd0, 64'h0000000089AB0000, 2, 0,
              8'h00, 64'd0, 64'h00000000000089AB);
    do_access(1'b0, MSIZE2, 1'b0, 64'h8000_0002, 64'd0, 64'h0000000089AB0000, 1, 0,
              8'h00, 64'd0, 64'hFFFFFFFFFFFF89AB);
    // SB lane 5 with junk upper data (shifted out the top)
    do_access(1'b1, MSIZE1, 1'b0, 64'h8000_0005, 64'h123456789ABCDE5A, 64'd0, 1, 0,
              8'h20, 64'hBCDE5A0000000000, 64'd0);
    // SD aligned, MSIZE8 ignores unsigned
    do_access(1'b1, MSIZE8, 1'b1, 64'h8000_3008, 64'h0123456789ABCDEF, 64'd0, 1, 2,
              8'hFF, 64'h0123456789ABCDEF, 64'd0);
    do_access(1'b0, MSIZE8, 1'b1, 64'h8000_3008, 64'd0, 64'hF0E1D2C3B4A59687, 1, 0,
              8'h00, 64'd0, 64'hF0E1D2C3B4A59687);

    misalign_case(MSIZE4, 64'h8000_0002);
    misalign_case(MSIZE2, 64'h8000_0001);
    misalign_case(MSIZE8, 64'h8000_0004);

    // Reset while in WAIT; late data_ok must be ignored
    begin
      dbus_req_t r;
      r = '0; r.valid = 1'b1; r.addr = 64'h8000_4000; r.size = MSIZE8;
      exp_req_q.push_back(r);
    end
    @(posedge clk); #1;
    mem_valid = 1'b1; mem_write = 1'b0; mem_size = MSIZE8; mem_unsigned = 1'b0;
    mem_addr = 64'h8000_4000; mem_wdata = 64'd0;
    @(negedge clk);
    check("rw_idle_stall", {63'd0, stall}, 64'd1);
    @(posedge clk); #1;
    @(negedge clk);
    check("rw_state_wait", {62'd0, state_dbg}, {62'd0, WAIT});
    @(posedge clk); #1;
    reset = 1'b1; mem_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("rw_valid_low", {63'd0, dreq.valid}, 64'd0);
    check("rw_stall_low", {63'd0, stall}, 64'd0);
    check("rw_state_idle", {62'd0, state_dbg}, {62'd0, IDLE});
    @(posedge clk); #1;
    dresp.data_ok = 1'b1; dresp.data = 64'hDEADDEADDEADDEAD;
    @(posedge clk); #1;
    dresp.data_ok = 1'b0;
    @(negedge clk);
    check("rw_late_load_data", load_data, 64'd0);
    check("rw_late_done", {63'd0, done}, 64'd0);
    check("rw_late_state", {62'd0, state_dbg}, {62'd0, IDLE});

    repeat (2) @(posedge clk);
    check("queues_empty", exp_req_q.size() + exp_q.size(), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_access_ctrl.md
Name: dmem_access_ctrl

Overview:
- Sequences every data-memory access issued by the memory stage of the 5-stage pipeline, and owns the dbus request/response handshake.
- Stalls the pipeline until the access completes, then holds the load result stable until the pipeline actually advances.
- Performs store lane alignment and byte strobes, plus load lane extraction with sign/zero extension.
- Sits between the EX/MEM pipeline register and the dbus; its stall output is ORed into the core's stall chain.

Parameters:
- XLEN, 64, data/address width; only 64 is supported.

Ports:
- clk  input  1  core clock
- reset  input  1  synchronous, active-high reset
- mem_valid  input  1  instruction in memory stage is a load or store
- mem_write  input  1  1 = store, 0 = load
- mem_size  input  msize_t  MSIZE1/2/4/8
- mem_unsigned  input  1  zero-extend the load (LBU/LHU/LWU)
- mem_addr  input  64  effective address (ALU result)
- mem_wdata  input  64  store data, unaligned (rs2 value)
- advance  input  1  EX/MEM register loads a new instruction this cycle
- dreq  output  dbus_req_t  data bus request
- dresp  input  dbus_resp_t  data bus response
- stall  output  1  hold the pipeline
- load_data  output  64  extended load result, valid when done=1 and mem_write=0
- done  output  1  access for the current instruction completed
- misalign  output  1  address not naturally aligned for mem_size

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high.
- States: IDLE, WAIT, DONE, held in a 2-bit state register.
- Reset values: state=IDLE, dreq.valid=0, stall=0, done=0, load_data=0, captured data register=0.
- misalign (combinational) = mem_valid & (addr[0] for MSIZE2 | addr[1:0]!=0 for MSIZE4 | addr[2:0]!=0 for MSIZE8).
  - A misaligned access never enters WAIT, is never sent to the bus, and drives stall=0.
  - Trap handling belongs to a later block.
- IDLE:
  - stall = mem_valid & ~misalign.
  - If that condition holds, go to WAIT next cycle.
- WAIT:
  - dreq.valid=1, stall=1.
  - dreq.addr/size/strobe/data are derived combinationally from the held EX/MEM inputs; the stall guarantees they are stable.
  - On dresp.data_ok: capture dresp.data, go to DONE.
  - data_ok in the first WAIT cycle is legal, giving a minimum stall of 2 cycles (IDLE-detect + WAIT).
- DONE:
  - dreq.valid=0, stall=0, done=1; load_data is driven from the captured data.
  - If advance=1, go to IDLE.
  - Otherwise stay in DONE: the access is not re-issued and data is held, even when an external stall (e.g. ifetch) freezes the pipeline.
- Store formatting:
  - dreq.data = mem_wdata << (8*addr[2:0]).
  - dreq.strobe = base << addr[2:0], with base = 8'h01 / 8'h03 / 8'h0f / 8'hff for MSIZE1/2/4/8.
  - Loads use strobe=0.
- Load formatting:
  - Shift the captured data right by 8*addr[2:0].
  - Take the low 8/16/32/64 bits, then sign-extend (mem_unsigned=0) or zero-extend.
  - MSIZE8 ignores mem_unsigned.
- dreq.size = mem_size; dreq.addr = mem_addr, not masked.
- Reset in WAIT: return to IDLE, and dreq.valid=0 from the next cycle. A late data_ok after reset is ignored.
- mem_valid dropping in WAIT is illegal (pipeline is stalled) and is flagged by an assertion.
- Data hazards are handled outside this block: no forwarding and no load-use detection here.

Decomposition:
- Shared package (common): add mem_ctl_state_t {IDLE, WAIT, DONE}.
- Reuse the existing msize_t, dbus_req_t and dbus_resp_t.
- One sub-module is natural: mem_lane_fmt (pure combinational).
  - Store path: shift and strobe.
  - Load path: extract and extend.
  - Instantiated once in this block; reusable for a future MMIO path.

Test Plan:
- LD, addr 0x80001000, data_ok after 3 cycles with data 0x1122334455667788 -> stall=1 for 4 cycles; then done=1, load_data=0x1122334455667788, dreq.valid=0.
- LB at addr ...3, dresp.data=0x00000000_80000000 -> load_data=0xFFFFFFFFFFFFFF80. Same access as LBU -> 0x80.
- SH at addr ...6, wdata=0xABCD -> dreq.strobe=8'hC0, dreq.data[63:48]=0xABCD, dreq.size=MSIZE2.
- LW at addr ...2 -> misalign=1, dreq.valid never 1, stall=0.
- Load completes while advance=0 for 5 cycles -> remains in DONE, no second dreq.valid, load_data stable; returns to IDLE the cycle after advance=1.
- reset asserted in WAIT -> next cycle dreq.valid=0, stall=0, state IDLE; a data_ok arriving afterwards does not change load_data.
